// File: rtl/fake_rd_axil_responder.sv
// AXI4-Lite register bank for the fake readout interface.
// Write address and write data are accepted independently into one-entry
// holding latches; the register commit happens on the first edge where both
// are available. Reads are served from the register contents present before
// the edge, so a write that commits on the same edge is not visible to a read
// accepted on that edge.
// Word slots at or above NUM_REGS answer SLVERR, read as zero and are never
// written.

module fake_rd_axil_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]                  wr_pulse
);

  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // register storage
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  // write holding latches
  logic                          aw_held;
  logic [IDX_W-1:0]              aw_idx_q;
  logic                          w_held;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]             w_strb_q;

  // write-side decode
  logic                          aw_hs;
  logic                          w_hs;
  logic                          commit;
  logic [IDX_W-1:0]              wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]             wr_strb;
  logic                          wr_ok;

  // read-side decode
  logic                          ar_hs;
  logic [IDX_W-1:0]              ar_idx;
  logic                          rd_ok;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_val;

  // protection bits and byte-lane address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // a held beat or a pending response blocks further acceptance on that channel
  assign S_AXI_AWREADY = !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY  = !w_held && !S_AXI_BVALID;
  assign S_AXI_ARREADY = !S_AXI_RVALID;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // commit once both halves are present, either held or arriving now
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
  assign wr_ok   = int'(wr_idx) < NUM_REGS;

  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_ok  = int'(ar_idx) < NUM_REGS;

  // read mux over the implemented registers; unimplemented slots read zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_val = regs[i];
    end
  end

  // flatten the register bank onto the readout-side bus
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = regs[g];
  end

  // capture AW and W beats that arrive ahead of their partner; clear on commit
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // bytewise register update on an in-range commit
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // one-cycle commit marker per register, raised even for an all-zero strobe
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit && wr_ok) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_idx == IDX_W'(i)) wr_pulse[i] <= 1'b1;
        end
      end
    end
  end

  // write response: raised on commit, held stable until BREADY is seen
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else if (commit) begin
      S_AXI_BVALID <= 1'b1;
      S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_BVALID && S_AXI_BREADY) begin
      S_AXI_BVALID <= 1'b0;
    end
  end

  // read response: data captured from pre-edge registers, held until RREADY
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_ok ? rd_val : '0;
      S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fake_rd_axil_responder.sv
// Directed bench for fake_rd_axil_responder. Inputs change and outputs are
// sampled 1 time unit after each rising edge.

module tb_fake_rd_axil_responder;

  logic         clk;
  logic         rst_n;
  logic [4:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [4:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] regs_out;
  logic [3:0]   wr_pulse;

  int tests = 0;
  int fails = 0;

  fake_rd_axil_responder dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .regs_out      (regs_out),
    .wr_pulse      (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input string tag, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] er, input logic [3:0] ep);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    chk({tag, "_awready"}, awready, 1'b1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, "_bvalid"}, bvalid, 1'b1);
    chk({tag, "_bresp"}, bresp, er);
    chk({tag, "_pulse"}, wr_pulse, ep);
    step();
    chk({tag, "_bvalid_clr"}, bvalid, 1'b0);
    chk({tag, "_pulse_clr"}, wr_pulse, 4'b0000);
  endtask

  task automatic do_read(input string tag, input logic [4:0] a, input logic [31:0] ed,
                         input logic [1:0] er);
    araddr = a; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, rvalid, 1'b1);
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_rresp"}, rresp, er);
    step();
    chk({tag, "_rvalid_clr"}, rvalid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0;
    rready = 1'b1;

    // reset state
    step(); step();
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_regs", regs_out, 128'h0);
    chk("rst_pulse", wr_pulse, 4'b0000);
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    rst_n = 1'b1;
    step();

    // write / read-back
    do_write("w0", 5'h00, 32'h0101FFFF, 4'hF, 2'b00, 4'b0001);
    do_read ("r0", 5'h00, 32'h0101FFFF, 2'b00);
    do_write("w1", 5'h04, 32'habcd0001, 4'hF, 2'b00, 4'b0010);
    do_read ("r1", 5'h04, 32'habcd0001, 2'b00);
    do_write("w2", 5'h08, 32'hdead0011, 4'hF, 2'b00, 4'b0100);
    do_read ("r2", 5'h08, 32'hdead0011, 2'b00);
    do_write("w3", 5'h0C, 32'hbeef0011, 4'hF, 2'b00, 4'b1000);
    do_read ("r3", 5'h0C, 32'hbeef0011, 2'b00);
    chk("regs_after_wr", regs_out, 128'hbeef0011_dead0011_abcd0001_0101FFFF);

    // byte strobes
    do_write("strb", 5'h04, 32'h12345678, 4'h3, 2'b00, 4'b0010);
    do_read ("strb_rd", 5'h04, 32'habcd5678, 2'b00);

    // W three cycles ahead of AW
    wdata = 32'hCAFE0000; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("wfirst_wready", wready, 1'b0);
    chk("wfirst_awready", awready, 1'b1);
    chk("wfirst_nobv", bvalid, 1'b0);
    step(); step();
    chk("wfirst_wready2", wready, 1'b0);
    chk("wfirst_nocommit", regs_out[95:64], 32'hdead0011);
    awaddr = 5'h08; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("wfirst_bvalid", bvalid, 1'b1);
    chk("wfirst_pulse", wr_pulse, 4'b0100);
    chk("wfirst_reg2", regs_out[95:64], 32'hCAFE0000);
    step();
    chk("wfirst_wready_back", wready, 1'b1);

    // AW three cycles ahead of W, after clearing reg2
    do_write("clr2", 5'h08, 32'h00000000, 4'hF, 2'b00, 4'b0100);
    awaddr = 5'h08; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("awfirst_awready", awready, 1'b0);
    chk("awfirst_wready", wready, 1'b1);
    chk("awfirst_nobv", bvalid, 1'b0);
    step(); step();
    chk("awfirst_nocommit", regs_out[95:64], 32'h00000000);
    wdata = 32'hCAFE0000; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("awfirst_bvalid", bvalid, 1'b1);
    chk("awfirst_reg2", regs_out[95:64], 32'hCAFE0000);
    step();
    chk("awfirst_awready_back", awready, 1'b1);

    // decode error
    do_write("slverr_w", 5'h10, 32'h55555555, 4'hF, 2'b10, 4'b0000);
    chk("slverr_regs", regs_out, 128'hbeef0011_CAFE0000_abcd5678_0101FFFF);
    do_read ("slverr_r10", 5'h10, 32'h0, 2'b10);
    do_read ("slverr_r1c", 5'h1C, 32'h0, 2'b10);

    // B backpressure
    bready = 1'b0;
    awaddr = 5'h0C; awvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", bvalid, 1'b1);
      chk("bp_bresp", bresp, 2'b00);
      chk("bp_awready", awready, 1'b0);
      chk("bp_wready", wready, 1'b0);
      step();
    end
    bready = 1'b1;
    chk("bp_bvalid_last", bvalid, 1'b1);
    step();
    chk("bp_bvalid_clr", bvalid, 1'b0);

    // R backpressure
    rready = 1'b0;
    araddr = 5'h0C; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rbp_rvalid", rvalid, 1'b1);
      chk("rbp_rdata", rdata, 32'h11111111);
      chk("rbp_arready", arready, 1'b0);
      step();
    end
    rready = 1'b1;
    step();
    chk("rbp_rvalid_clr", rvalid, 1'b0);

    // read and commit to the same register on the same edge
    awaddr = 5'h00; awvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 5'h00; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("haz_rdata", rdata, 32'h0101FFFF);
    chk("haz_reg0", regs_out[31:0], 32'h0BADF00D);
    chk("haz_bvalid", bvalid, 1'b1);
    step();

    // reset with W held
    wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("rstw_held", wready, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_wready", wready, 1'b1);
    chk("rstw_regs", regs_out, 128'h0);
    step(); step();
    rst_n = 1'b1;
    awaddr = 5'h00; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("rstw_nocommit", bvalid, 1'b0);
    chk("rstw_nopulse", wr_pulse, 4'b0000);
    chk("rstw_awheld", awready, 1'b0);
    do_read("rstw_r0", 5'h00, 32'h0, 2'b00);
    do_read("rstw_r1", 5'h04, 32'h0, 2'b00);
    do_read("rstw_r2", 5'h08, 32'h0, 2'b00);
    do_read("rstw_r3", 5'h0C, 32'h0, 2'b00);

    // complete the held AW, then reset while BVALID is high
    wdata = 32'h2468ACE0; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("rstb_bvalid", bvalid, 1'b1);
    chk("rstb_reg0", regs_out[31:0], 32'h2468ACE0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstb_bvalid_clr", bvalid, 1'b0);
    chk("rstb_pulse_clr", wr_pulse, 4'b0000);
    chk("rstb_regs", regs_out, 128'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    do_read("rstb_r0", 5'h00, 32'h0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fake_rd_axil_responder.md
# fake_rd_axil_responder

AXI4-Lite slave (responder) exposing a small bank of 32-bit read/write registers to the PS-side AXI4-Lite master. It sits at the `S00_AXI` slave address inside the fake readout interface IP and answers the write-then-read register traffic the master issues. It drives the register contents and per-register write strobes to the readout logic behind it.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: data width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 5: byte-address width; decoded word slots = 2^(C_S_AXI_ADDR_WIDTH-2).
- `NUM_REGS`, 4: implemented registers, 1..2^(C_S_AXI_ADDR_WIDTH-2).

Ports (name, direction, width, meaning):
- `S_AXI_ACLK` in 1: the single clock.
- `S_AXI_ARESETN` in 1: reset, asynchronous, active-low.
- `S_AXI_AWADDR` in C_S_AXI_ADDR_WIDTH: write address.
- `S_AXI_AWPROT` in 3: ignored.
- `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1: AW handshake.
- `S_AXI_WDATA` in 32, `S_AXI_WSTRB` in 4: write data and byte enables.
- `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1: W handshake.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1: write response.
- `S_AXI_ARADDR` in C_S_AXI_ADDR_WIDTH, `S_AXI_ARPROT` in 3 (ignored): read address.
- `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1: AR handshake.
- `S_AXI_RDATA` out 32, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1: read data.
- `regs_out` out NUM_REGS*32: register i on bits [32i+31:32i].
- `wr_pulse` out NUM_REGS: bit i high for one cycle after register i is committed.

## Operation
- **Decode.** Word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] is ignored.
  - Index < NUM_REGS: OKAY (2'b00).
  - Otherwise: SLVERR (2'b10). No register changes. Read data is 0.
- **Write path.** AW and W are accepted independently, in either order, each into a one-entry holding latch.
  - `AWREADY` = !aw_held && !BVALID.
  - `WREADY` = !w_held && !BVALID.
- **Commit edge.** The commit happens on the first edge where the address and the data are both available, each either already held or handshaking that cycle. On that edge:
  - The addressed register is updated bytewise per WSTRB (a 0 strobe keeps the old byte).
  - `wr_pulse[i]` is set for one cycle. It is set even when WSTRB = 0. It is not set on SLVERR.
  - `BVALID` is set with `BRESP`.
  - Both latches are cleared.
- **Write response.** `BVALID` holds, with `BRESP` stable, until the edge where BREADY is sampled high. While `BVALID` is high, no AW or W is accepted.
- **Read path.** `ARREADY` = !RVALID.
  - On the AR handshake edge, `RDATA`/`RRESP` are registered from the pre-edge register value. A write committing on the same edge is not visible to that read.
  - `RVALID` then holds, with data stable, until RREADY is sampled high.
- **Independence.** Read and write channels never stall each other.
- **Reset values.** While S_AXI_ARESETN is low:
  - All registers, `regs_out`, `wr_pulse`, `BVALID`, `RVALID`, `BRESP`, `RRESP`, `RDATA` = 0.
  - Latches are cleared.
  - `AWREADY`/`WREADY`/`ARREADY` = 1, since they are combinational from the cleared state.
- **Reset mid-transaction.** Asserting reset mid-transaction discards held AW/W and any pending response immediately (asynchronous). No partial write occurs.

## Timing
- AW and W valid in the same cycle with both readies high: commit on that edge; `BVALID` high the next cycle (latency 1).
- W arrives k cycles before AW: W is accepted, then `WREADY` stays low. Commit happens on the AW handshake edge; `BVALID` is high the cycle after.
- AW arrives before W: symmetric to the above.
- With BREADY tied high: `BVALID` lasts 1 cycle. Back-to-back writes sustain one per 2 cycles.
- Read: `RVALID` high 1 cycle after the AR handshake. With RREADY high, one read per 2 cycles.
- `regs_out` reflects the new value in the cycle after the commit edge, the same cycle as `BVALID` and `wr_pulse`.

## Test plan
- **Write/read-back.** Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to offsets 0x0/0x4/0x8/0xC (WSTRB=0xF), each followed by a read of the same offset.
  - Every BRESP/RRESP = OKAY; read data equals the written data.
  - `regs_out` = {beef0011, dead0011, abcd0001, 0101FFFF}.
- **Byte strobes.** With reg1 = 0xabcd0001, write 0x12345678 with WSTRB=0x3 to 0x4.
  - Read returns 0xabcd5678.
  - `wr_pulse` = 4'b0010 for exactly one cycle.
- **Channel ordering.** Drive W 3 cycles before AW (data 0xCAFE0000 to 0x8).
  - `WREADY` pulses once; no commit before AW.
  - `BVALID` is high the cycle after the AW handshake; reg2 = 0xCAFE0000.
  - Repeat with AW first: same result.
- **Decode error.** Write 0x55555555 to 0x10, then read 0x10 and 0x1C.
  - BRESP = SLVERR; all registers unchanged; no `wr_pulse`.
  - Both reads return RDATA = 0 with RRESP = SLVERR.
- **Backpressure and same-edge hazard.**
  - Hold BREADY low for 5 cycles after a write: `BVALID`/`BRESP` stay stable, and `AWREADY`/`WREADY` stay low for 5 cycles.
  - Hold RREADY low for 5 cycles after a read: `RVALID`/`RDATA` stay stable.
  - Issue a read of 0x0 on the same edge as a commit to 0x0: the read returns the old value.
- **Reset mid-operation.** Accept W only, then assert S_AXI_ARESETN low for 2 cycles; alternatively assert it while `BVALID` is high.
  - Outputs clear asynchronously to the reset values.
  - After release, an AW alone produces no commit, and all registers read 0.
